adder_result_bcd: RTL and testbench

Sequential binary-to-BCD converter sitting directly downstream of `eight_bit_adder`. It captures the adder's `{Cout,Sum}` result through a valid/ready handshake and converts it to packed decimal digits by shift-and-add-3 (double dabble). It presents the digits to the calculator's display/output stage with a valid/ready handshake. One conversion is in flight at a time; the adder output is sampled once per accept.

---
 rtl/calc_pkg.sv | 39 +++
 rtl/bcd_digit_adjust.sv | 18 +
 rtl/adder_result_bcd.sv | 124 ++++++++++++
 tb/tb_adder_result_bcd.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// -----------------------------------------------------------------------------
// calc_pkg
// Declarations shared by the calculator datapath blocks.
//   CALC_N           adder operand width
//   calc_bcd_digits  number of decimal digits needed to hold any value of a
//                    given bit width
//   bcd_state_e      binary-to-BCD converter FSM states
// -----------------------------------------------------------------------------
package calc_pkg;

    localparam int CALC_N = 8;

    // Digit count is found by dividing the largest representable value down
    // by ten. It is evaluated at elaboration time only. The loop bound of 20
    // covers the 64-bit range.
    function automatic int calc_bcd_digits(input int bits);
        longint unsigned max_val;
        int              digits;
        max_val = (longint'(1) << bits) - 1;
        digits  = 0;
        for (int i = 0; i < 20; i++) begin
            if (max_val != 0) begin
                digits++;
                max_val = max_val / 10;
            end
        end
        if (digits == 0) begin
            digits = 1;
        end
        return digits;
    endfunction

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } bcd_state_e;

endpackage

// File: rtl/bcd_digit_adjust.sv
// -----------------------------------------------------------------------------
// bcd_digit_adjust
// Performs the add-3 correction for one double-dabble step. The correction
// applies to a digit of 5 or more, because that digit would reach 10 or more
// after the next left shift.
//   digit     in   4  scratch BCD digit before the shift
//   adjusted  out  4  digit with +3 applied when digit >= 5
// -----------------------------------------------------------------------------
module bcd_digit_adjust (
    input  logic [3:0] digit,
    output logic [3:0] adjusted
);

    // Legal digits are at most 9, which gives at most 12. The sum cannot
    // overflow 4 bits.
    assign adjusted = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/adder_result_bcd.sv
// -----------------------------------------------------------------------------
// adder_result_bcd
// Accepts the {Cout,Sum} result of the upstream adder and converts it to packed
// BCD by shift-and-add-3. Both sides use a valid/ready handshake. Only one
// conversion is in flight at a time.
//   clk        in   1         clock, rising edge
//   rst        in   1         asynchronous active-high reset
//   in_valid   in   1         upstream result available
//   in_ready   out  1         converter idle and able to accept
//   in_cout    in   1         adder carry out (value MSB)
//   in_sum     in   N         adder sum (value low bits)
//   out_valid  out  1         bcd holds a finished conversion
//   out_ready  in   1         downstream takes the result
//   bcd        out  4*DIGITS  packed digits, units digit in [3:0]
//   busy       out  1         conversion running or result waiting
// -----------------------------------------------------------------------------
module adder_result_bcd
    import calc_pkg::*;
#(
    parameter int N      = CALC_N,
    parameter int DIGITS = calc_bcd_digits(N + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_cout,
    input  logic [N-1:0]      in_sum,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [4*DIGITS-1:0] bcd,
    output logic              busy
);

    localparam int DW = 4 * DIGITS;     // scratch digit field width
    localparam int SW = DW + N + 1;     // digits plus binary value
    localparam int CW = $clog2(N + 2);  // holds N+1 down to 0

    bcd_state_e      state;
    bcd_state_e      state_next;
    logic [CW-1:0]   cnt;
    logic [SW-1:0]   scratch;
    logic [DW-1:0]   adj_digits;
    logic [SW-1:0]   pre_shift;
    logic [SW-1:0]   scratch_next;
    logic            accept;
    logic            last_shift;

    // Correct every scratch digit in parallel before the shift.
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .digit    (scratch[N+1+4*g +: 4]),
            .adjusted (adj_digits[4*g +: 4])
        );
    end

    assign pre_shift    = {adj_digits, scratch[N:0]};
    assign scratch_next = pre_shift << 1;
    assign accept       = in_valid && in_ready;
    assign last_shift   = (cnt == CW'(1));

    // State register
    // NOTE: sequential state uses non-blocking assignments, so every flop
    // samples values from before the edge and the processes do not race.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    // NOTE: each always_comb output gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)                  state_next = SHIFT;
            SHIFT:   if (last_shift)              state_next = DONE;
            DONE:    if (out_valid && out_ready)  state_next = IDLE;
            default:                              state_next = IDLE;
        endcase
    end

    // Handshake outputs are decoded from the state alone.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE:    in_ready  = 1'b1;
            SHIFT:   busy      = 1'b1;
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: in_ready  = 1'b1;
        endcase
    end

    // Datapath: load on accept, shift while converting. The bcd register
    // loads only on the final shift, so it holds the previous result until
    // the new one is complete.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scratch <= '0;
            cnt     <= '0;
            bcd     <= '0;
        end else begin
            if (accept) begin
                scratch <= {{DW{1'b0}}, in_cout, in_sum};
                cnt     <= CW'(N + 1);
            end else if (state == SHIFT) begin
                scratch <= scratch_next;
                cnt     <= cnt - CW'(1);
                if (last_shift) begin
                    bcd <= scratch_next[SW-1 -: DW];
                end
            end
        end
    end

endmodule

// File: tb/tb_adder_result_bcd.sv
// -----------------------------------------------------------------------------
// tb_adder_result_bcd
// Self-checking bench for adder_result_bcd. It applies a directed vector table
// and hand-written corner sequences, then sweeps all input values in shuffled
// order. A scoreboard queue holds the expected digits for every accepted input.
// -----------------------------------------------------------------------------
module tb_adder_result_bcd;
    import calc_pkg::*;

    localparam int N      = CALC_N;
    localparam int DIGITS = 3;
    localparam int LAT    = N + 1;

    logic          clk       = 1'b0;
    logic          rst       = 1'b1;
    logic          in_valid  = 1'b0;
    logic          in_ready;
    logic          in_cout   = 1'b0;
    logic [N-1:0]  in_sum    = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [11:0]   bcd;
    logic          busy;

    adder_result_bcd #(.N(N), .DIGITS(DIGITS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_cout   (in_cout),
        .in_sum    (in_sum),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bcd       (bcd),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cycle   = 0;
    logic [11:0] sb[$];
    logic [11:0] mon_want;

    always @(posedge clk) cycle <= cycle + 1;

    typedef struct {
        logic        cout;
        logic [7:0]  sum;
        logic [11:0] want;
    } vec_t;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] want);
        n_tests++;
        if (actual !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, want, $time);
        end
    endtask

    // Reference model: decimal digits by division.
    function automatic logic [11:0] to_bcd(input int v);
        return {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // The output handshake completes on the next rising edge. Compare against
    // the oldest expected result.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_output", {20'h0, bcd}, 32'hFFFF_FFFF);
            end else begin
                mon_want = sb.pop_front();
                check("scoreboard_bcd", {20'h0, bcd}, {20'h0, mon_want});
            end
        end
    end

    // Drive one input and wait (bounded) for in_ready. On the accept edge,
    // push the expected result. The task is entered and left at posedge+1.
    task automatic accept(input logic c, input logic [7:0] s, input logic [11:0] want,
                          input bit hold, output int acc_cycle);
        in_cout  = c;
        in_sum   = s;
        in_valid = 1'b1;
        for (int i = 0; i < 100 && !in_ready; i++) begin
            @(posedge clk);
            #1;
        end
        acc_cycle = -1;
        if (!in_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
            in_valid = hold;
            return;
        end
        @(posedge clk);
        sb.push_back(want);
        #1;
        acc_cycle = cycle;
        if (!hold) in_valid = 1'b0;
    endtask

    // Count edges from the accept edge until out_valid is seen. Also record
    // whether in_ready went high during the conversion.
    task automatic wait_valid(output int lat, output bit ready_seen);
        lat        = 0;
        ready_seen = 1'b0;
        while (!out_valid && lat < 50) begin
            if (in_ready) ready_seen = 1'b1;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sb.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        check("drain_empty", sb.size(), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs[6];
        int   lat;
        bit   rdy_seen;
        int   acc;
        int   prev_acc;
        bit   stable;
        int   order[512];

        vecs[0] = '{1'b0, 8'd0,   12'h000};
        vecs[1] = '{1'b1, 8'd255, 12'h511};
        vecs[2] = '{1'b0, 8'd9,   12'h009};
        vecs[3] = '{1'b0, 8'd99,  12'h099};
        vecs[4] = '{1'b0, 8'd200, 12'h200};
        vecs[5] = '{1'b1, 8'd243, 12'h499};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",  {31'h0, in_ready},  32'd1);
        check("rst_out_valid", {31'h0, out_valid}, 32'd0);
        check("rst_busy",      {31'h0, busy},      32'd0);
        check("rst_bcd",       {20'h0, bcd},       32'h000);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed table: latency, in_ready during conversion, value, release.
        out_ready = 1'b1;
        foreach (vecs[i]) begin
            accept(vecs[i].cout, vecs[i].sum, vecs[i].want, 1'b0, acc);
            wait_valid(lat, rdy_seen);
            check("vec_latency",        lat,                     LAT);
            check("vec_in_ready_low",   {31'h0, rdy_seen},       32'd0);
            check("vec_bcd",            {20'h0, bcd},            {20'h0, vecs[i].want});
            @(posedge clk);
            #1;
            check("vec_in_ready_after", {31'h0, in_ready},       32'd1);
            check("vec_out_valid_drop", {31'h0, out_valid},      32'd0);
        end
        drain();

        // Back-to-back with in_valid held high. Accepts are N+3 cycles apart.
        prev_acc = -1;
        accept(1'b0, 8'd9,   12'h009, 1'b1, acc); prev_acc = acc;
        accept(1'b0, 8'd100, 12'h100, 1'b1, acc);
        check("b2b_gap_1", acc - prev_acc, N + 3); prev_acc = acc;
        accept(1'b0, 8'd255, 12'h255, 1'b1, acc);
        check("b2b_gap_2", acc - prev_acc, N + 3);
        in_valid = 1'b0;
        drain();

        // Back-pressure: 329 is held while in_valid pulses are ignored.
        out_ready = 1'b0;
        accept(1'b1, 8'd73, 12'h329, 1'b0, acc);
        wait_valid(lat, rdy_seen);
        check("hold_latency", lat, LAT);
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_valid = (i % 3 == 0);
            in_cout  = 1'($urandom_range(0, 1));
            in_sum   = 8'($urandom_range(0, 255));
            @(posedge clk);
            #1;
            if (!(out_valid === 1'b1 && bcd === 12'h329 && in_ready === 1'b0)) stable = 1'b0;
        end
        in_valid = 1'b0;
        check("hold_stable",  {31'h0, stable}, 32'd1);
        check("hold_pending", sb.size(),       32'd1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("hold_release_valid", {31'h0, out_valid}, 32'd0);
        check("hold_release_ready", {31'h0, in_ready},  32'd1);
        check("hold_release_sb",    sb.size(),          32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("hold_no_ghost", {31'h0, busy}, 32'd0);

        // Reset during the 4th SHIFT cycle of a conversion of 77.
        accept(1'b0, 8'd77, 12'h077, 1'b0, acc);
        repeat (3) @(posedge clk);
        #1;
        check("abort_busy_before", {31'h0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("abort_out_valid", {31'h0, out_valid}, 32'd0);
        check("abort_bcd",       {20'h0, bcd},       32'h000);
        check("abort_in_ready",  {31'h0, in_ready},  32'd1);
        check("abort_busy",      {31'h0, busy},      32'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        accept(1'b0, 8'd42, 12'h042, 1'b0, acc);
        wait_valid(lat, rdy_seen);
        check("post_abort_latency", lat,          LAT);
        check("post_abort_bcd",     {20'h0, bcd}, 32'h042);
        drain();

        // Sweep all values in shuffled order.
        foreach (order[i]) order[i] = i;
        for (int i = 511; i > 0; i--) begin
            int j;
            int t;
            j        = int'($urandom_range(0, i));
            t        = order[i];
            order[i] = order[j];
            order[j] = t;
        end
        foreach (order[i]) begin
            logic [8:0] v;
            v = 9'(order[i]);
            accept(v[8], v[7:0], to_bcd(order[i]), 1'b0, acc);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
